// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry
// Keypad-driven operand entry sequencer feeding a 3-digit signed BCD
// add/subtract unit. Collects operand A, operator, operand B and '=',
// then presents the operands with a valid/ready handshake.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   key_valid/key_code key strobe and code (0-9 digit, 10 '+', 11 '-',
//                      12 '=', 13 clear, 14 sign toggle, others ignored)
//   op_ready           downstream accepts operands
//   A, B               BCD operands, MS digit in the top nibble
//   Asign, Bsign, Mode operand signs (1 = negative), 0 = add / 1 = subtract
//   op_valid           operands complete and stable
//   entry_val/_sign    operand currently being typed, for the display
//   ovf_err            sticky: a digit was dropped on a full operand
//   res, res_sign      (BCD_ENTRY_CHAIN_EN only) adder result for chaining
//
// Optional feature: define BCD_ENTRY_CHAIN_EN to let '+'/'-' after a
// completed calculation reuse the adder result as the next operand A.
module bcd_operand_entry #(
  parameter int unsigned NDIG  = 3,
  parameter int unsigned KEY_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [KEY_W-1:0]    key_code,
  input  logic                op_ready,
`ifdef BCD_ENTRY_CHAIN_EN
  input  logic [4*NDIG-1:0]   res,
  input  logic                res_sign,
`endif
  output logic [4*NDIG-1:0]   A,
  output logic [4*NDIG-1:0]   B,
  output logic                Asign,
  output logic                Bsign,
  output logic                Mode,
  output logic                op_valid,
  output logic [4*NDIG-1:0]   entry_val,
  output logic                entry_sign,
  output logic                ovf_err
);

  localparam int unsigned OW = 4 * NDIG;
  localparam int unsigned CW = $clog2(NDIG + 1);

  localparam logic [KEY_W-1:0] K_PLUS  = KEY_W'(10);
  localparam logic [KEY_W-1:0] K_MINUS = KEY_W'(11);
  localparam logic [KEY_W-1:0] K_EQ    = KEY_W'(12);
  localparam logic [KEY_W-1:0] K_CLR   = KEY_W'(13);
  localparam logic [KEY_W-1:0] K_TOG   = KEY_W'(14);
  localparam logic [CW-1:0]    CNT_FULL = CW'(NDIG);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt_a, cnt_b, cnt_a_n, cnt_b_n;
  logic [OW-1:0]  a_n, b_n;
  logic           as_n, bs_n, mode_n, ovf_n;

  // Key decode
  logic           k_digit, k_op, k_eq, k_clr, k_tog;
  logic [3:0]     digit;

  assign digit   = key_code[3:0];
  assign k_digit = key_valid && (key_code < KEY_W'(10));
  assign k_op    = key_valid && ((key_code == K_PLUS) || (key_code == K_MINUS));
  assign k_eq    = key_valid && (key_code == K_EQ);
  assign k_clr   = key_valid && (key_code == K_CLR);
  assign k_tog   = key_valid && (key_code == K_TOG);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_A;
      cnt_a      <= '0;
      cnt_b      <= '0;
      A          <= '0;
      B          <= '0;
      Asign      <= 1'b0;
      Bsign      <= 1'b0;
      Mode       <= 1'b0;
      op_valid   <= 1'b0;
      entry_val  <= '0;
      entry_sign <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt_a      <= cnt_a_n;
      cnt_b      <= cnt_b_n;
      A          <= a_n;
      B          <= b_n;
      Asign      <= as_n;
      Bsign      <= bs_n;
      Mode       <= mode_n;
      op_valid   <= (state_n == S_REQ);
      entry_val  <= (state_n == S_A) ? a_n  : b_n;
      entry_sign <= (state_n == S_A) ? as_n : bs_n;
      ovf_err    <= ovf_n;
    end
  end

  // Next-state and next-operand logic
  always_comb begin
    state_n = state;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    a_n     = A;
    b_n     = B;
    as_n    = Asign;
    bs_n    = Bsign;
    mode_n  = Mode;
    ovf_n   = ovf_err;

    if (k_clr) begin
      // Clear wins over everything, including a pending handshake
      state_n = S_A;
      cnt_a_n = '0;
      cnt_b_n = '0;
      a_n     = '0;
      b_n     = '0;
      as_n    = 1'b0;
      bs_n    = 1'b0;
      mode_n  = 1'b0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (k_digit) begin
            if (cnt_a == CNT_FULL) begin
              ovf_n = 1'b1;
            end else begin
              a_n = (A << 4) | OW'(digit);
              // Leading zeros do not consume a digit position
              if (!((cnt_a == '0) && (digit == 4'd0))) cnt_a_n = cnt_a + CW'(1);
            end
          end else if (k_op) begin
            mode_n  = (key_code == K_MINUS);
            state_n = S_B;
          end else if (k_tog) begin
            as_n = ~Asign;
          end
        end

        S_B: begin
          if (k_digit) begin
            if (cnt_b == CNT_FULL) begin
              ovf_n = 1'b1;
            end else begin
              b_n = (B << 4) | OW'(digit);
              if (!((cnt_b == '0) && (digit == 4'd0))) cnt_b_n = cnt_b + CW'(1);
            end
          end else if (k_op) begin
            mode_n = (key_code == K_MINUS);
          end else if (k_eq) begin
            state_n = S_REQ;
          end else if (k_tog) begin
            bs_n = ~Bsign;
          end
        end

        S_REQ: begin
          // Operands frozen; only the handshake (or clear) leaves this state
          if (op_valid && op_ready) state_n = S_DONE;
        end

        S_DONE: begin
          if (k_digit) begin
            // New calculation: first digit starts a fresh operand A
            state_n = S_A;
            a_n     = OW'(digit);
            b_n     = '0;
            as_n    = 1'b0;
            bs_n    = 1'b0;
            mode_n  = 1'b0;
            cnt_a_n = (digit == 4'd0) ? CW'(0) : CW'(1);
            cnt_b_n = '0;
          end
`ifdef BCD_ENTRY_CHAIN_EN
          else if (k_op) begin
            // Chain: previous result becomes a full operand A
            state_n = S_B;
            a_n     = res;
            as_n    = res_sign;
            b_n     = '0;
            bs_n    = 1'b0;
            mode_n  = (key_code == K_MINUS);
            cnt_a_n = CNT_FULL;
            cnt_b_n = '0;
          end
`endif
        end

        default: state_n = S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
module tb_bcd_operand_entry;

  localparam int unsigned NDIG  = 3;
  localparam int unsigned KEY_W = 5;
  localparam int unsigned OW    = 4 * NDIG;
  localparam int unsigned TMO   = 50;

  typedef struct packed {
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic          as;
    logic          bs;
    logic          m;
  } txn_t;

  logic             clk;
  logic             rst_n;
  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             op_ready;
  logic [OW-1:0]    res;
  logic             res_sign;
  logic [OW-1:0]    A, B, entry_val;
  logic             Asign, Bsign, Mode, op_valid, entry_sign, ovf_err;

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];

  bcd_operand_entry #(.NDIG(NDIG), .KEY_W(KEY_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .op_ready   (op_ready),
`ifdef BCD_ENTRY_CHAIN_EN
    .res        (res),
    .res_sign   (res_sign),
`endif
    .A          (A),
    .B          (B),
    .Asign      (Asign),
    .Bsign      (Bsign),
    .Mode       (Mode),
    .op_valid   (op_valid),
    .entry_val  (entry_val),
    .entry_sign (entry_sign),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One key strobe; entered and left at 1 time unit after a rising edge
  task automatic press(input int k);
    key_code  = KEY_W'(k);
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = '0;
  endtask

  task automatic test_reset;
    logic [3*OW+6-1:0] all_out;
    rst_n = 1'b0; key_valid = 1'b0; key_code = '0; op_ready = 1'b0;
    res = '0; res_sign = 1'b0;
    #12;
    all_out = {A, B, Asign, Bsign, Mode, op_valid, entry_val, entry_sign, ovf_err};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_initial: outputs=%h required 0", all_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    press(3); press(4);
    checks++;
    if (entry_val !== 12'h034) begin
      errors++; $display("FAIL reset_pre_entry: entry_val=%h required 034", entry_val);
    end
    rst_n = 1'b0;
    #2;
    all_out = {A, B, Asign, Bsign, Mode, op_valid, entry_val, entry_sign, ovf_err};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_mid_entry: outputs=%h required 0", all_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    press(5);
    checks++;
    if (A !== 12'h005 || entry_val !== 12'h005) begin
      errors++; $display("FAIL reset_restart: A=%h entry_val=%h required 005/005", A, entry_val);
    end
  endtask

  task automatic test_basic_add;
    txn_t got, exp;
    int   n;
    press(13);
    op_ready = 1'b1;
    press(3); press(4); press(8);
    checks++;
    if (entry_val !== 12'h348 || A !== 12'h348) begin
      errors++; $display("FAIL add_entry_a: A=%h entry_val=%h required 348", A, entry_val);
    end
    press(10);
    checks++;
    if (Mode !== 1'b0 || entry_val !== 12'h000) begin
      errors++; $display("FAIL add_op: Mode=%b entry_val=%h required 0/000", Mode, entry_val);
    end
    press(7); press(8); press(6);
    exp_q.push_back('{a: 12'h348, b: 12'h786, as: 1'b0, bs: 1'b0, m: 1'b0});
    press(12);
    checks++;
    if (op_valid !== 1'b1) begin
      errors++; $display("FAIL add_valid_latency: op_valid=%b required 1", op_valid);
    end
    n = 0;
    while (!(op_valid && op_ready) && n < TMO) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= TMO) begin
      errors++; $display("FAIL add_handshake: timeout waiting op_valid, got 0 required 1");
    end else begin
      exp = exp_q.pop_front();
      got = '{a: A, b: B, as: Asign, bs: Bsign, m: Mode};
      if (got !== exp) begin
        errors++; $display("FAIL add_operands: got=%h required=%h", got, exp);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (op_valid !== 1'b0) begin
      errors++; $display("FAIL add_valid_one_cycle: op_valid=%b required 0", op_valid);
    end
  endtask

  task automatic test_signs_handshake;
    txn_t got, exp;
    int   n;
    op_ready = 1'b0;
    press(3);
    checks++;
    if (A !== 12'h003 || B !== 12'h000 || Mode !== 1'b0 || op_valid !== 1'b0) begin
      errors++; $display("FAIL done_new_digit: A=%h B=%h Mode=%b op_valid=%b required 003/000/0/0",
                         A, B, Mode, op_valid);
    end
    press(4); press(8); press(14);
    checks++;
    if (Asign !== 1'b1 || entry_sign !== 1'b1) begin
      errors++; $display("FAIL sign_toggle_a: Asign=%b entry_sign=%b required 1/1", Asign, entry_sign);
    end
    press(11); press(7); press(8); press(6); press(14);
    exp_q.push_back('{a: 12'h348, b: 12'h786, as: 1'b1, bs: 1'b1, m: 1'b1});
    press(12);
    for (int i = 0; i < 5; i++) begin
      got = '{a: A, b: B, as: Asign, bs: Bsign, m: Mode};
      checks++;
      if (op_valid !== 1'b1 || got !== exp_q[0]) begin
        errors++; $display("FAIL hold_stable[%0d]: op_valid=%b got=%h required 1/%h",
                           i, op_valid, got, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    op_ready = 1'b1;
    n = 0;
    while (!(op_valid && op_ready) && n < TMO) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= TMO) begin
      errors++; $display("FAIL signs_handshake: timeout waiting op_valid, got 0 required 1");
    end else begin
      exp = exp_q.pop_front();
      got = '{a: A, b: B, as: Asign, bs: Bsign, m: Mode};
      if (got !== exp) begin
        errors++; $display("FAIL signs_operands: got=%h required=%h", got, exp);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (op_valid !== 1'b0) begin
      errors++; $display("FAIL signs_valid_drop: op_valid=%b required 0", op_valid);
    end
    op_ready = 1'b0;
  endtask

  task automatic test_overflow;
    press(13);
    press(0); press(0);
    checks++;
    if (entry_val !== 12'h000 || ovf_err !== 1'b0) begin
      errors++; $display("FAIL leading_zero: entry_val=%h ovf_err=%b required 000/0", entry_val, ovf_err);
    end
    press(1); press(2); press(3); press(4);
    checks++;
    if (A !== 12'h123 || ovf_err !== 1'b1 || entry_val !== 12'h123) begin
      errors++; $display("FAIL overflow: A=%h ovf_err=%b entry_val=%h required 123/1/123",
                         A, ovf_err, entry_val);
    end
    press(15); press(12);
    checks++;
    if (A !== 12'h123 || op_valid !== 1'b0 || Mode !== 1'b0) begin
      errors++; $display("FAIL ignored_keys_a: A=%h op_valid=%b Mode=%b required 123/0/0",
                         A, op_valid, Mode);
    end
  endtask

  task automatic test_clear_in_req;
    op_ready = 1'b0;
    press(10); press(9); press(12);
    checks++;
    if (op_valid !== 1'b1 || B !== 12'h009) begin
      errors++; $display("FAIL req_entered: op_valid=%b B=%h required 1/009", op_valid, B);
    end
    press(5); press(14); press(11);
    checks++;
    if (op_valid !== 1'b1 || B !== 12'h009 || Bsign !== 1'b0 || Mode !== 1'b0 || A !== 12'h123) begin
      errors++; $display("FAIL req_ignore: op_valid=%b A=%h B=%h Bsign=%b Mode=%b required 1/123/009/0/0",
                         op_valid, A, B, Bsign, Mode);
    end
    press(13);
    checks++;
    if (op_valid !== 1'b0 || A !== 12'h000 || B !== 12'h000 || ovf_err !== 1'b0) begin
      errors++; $display("FAIL req_clear: op_valid=%b A=%h B=%h ovf_err=%b required 0/000/000/0",
                         op_valid, A, B, ovf_err);
    end
  endtask

  task automatic test_done_keys;
    txn_t got, exp;
    int   n;
    op_ready = 1'b1;
    press(2); press(10); press(3);
    exp_q.push_back('{a: 12'h002, b: 12'h003, as: 1'b0, bs: 1'b0, m: 1'b0});
    press(12);
    n = 0;
    while (!(op_valid && op_ready) && n < TMO) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= TMO) begin
      errors++; $display("FAIL done_handshake: timeout waiting op_valid, got 0 required 1");
    end else begin
      exp = exp_q.pop_front();
      got = '{a: A, b: B, as: Asign, bs: Bsign, m: Mode};
      if (got !== exp) begin
        errors++; $display("FAIL done_operands: got=%h required=%h", got, exp);
      end
    end
    @(posedge clk); #1;
`ifdef BCD_ENTRY_CHAIN_EN
    res = 12'h005; res_sign = 1'b1;
    press(10);
    checks++;
    if (A !== 12'h005 || Asign !== 1'b1 || B !== 12'h000 || Mode !== 1'b0 || entry_val !== 12'h000) begin
      errors++; $display("FAIL done_chain_plus: A=%h Asign=%b B=%h Mode=%b entry_val=%h required 005/1/000/0/000",
                         A, Asign, B, Mode, entry_val);
    end
    press(13);
`else
    press(10); press(12);
    checks++;
    if (A !== 12'h002 || B !== 12'h003 || Mode !== 1'b0 || op_valid !== 1'b0) begin
      errors++; $display("FAIL done_ignore_op: A=%h B=%h Mode=%b op_valid=%b required 002/003/0/0",
                         A, B, Mode, op_valid);
    end
`endif
    op_ready = 1'b0;
  endtask

`ifdef BCD_ENTRY_CHAIN_EN
  task automatic test_chain;
    txn_t got, exp;
    int   n;
    op_ready = 1'b1;
    press(13);
    press(3); press(4); press(8); press(10); press(7); press(8); press(6);
    press(12);
    n = 0;
    while (!(op_valid && op_ready) && n < TMO) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    res = 12'h134; res_sign = 1'b0;
    op_ready = 1'b0;
    press(11);
    press(4);
    checks++;
    if (A !== 12'h134 || ovf_err !== 1'b0) begin
      errors++; $display("FAIL chain_a_loaded: A=%h ovf_err=%b required 134/0", A, ovf_err);
    end
    press(13);
    press(3); press(4); press(8); press(10); press(7); press(8); press(6);
    op_ready = 1'b1;
    press(12);
    n = 0;
    while (!(op_valid && op_ready) && n < TMO) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    op_ready = 1'b0;
    press(11); press(5);
    exp_q.push_back('{a: 12'h134, b: 12'h005, as: 1'b0, bs: 1'b0, m: 1'b1});
    press(12);
    checks++;
    if (op_valid !== 1'b1) begin
      errors++; $display("FAIL chain_valid: op_valid=%b required 1", op_valid);
    end
    op_ready = 1'b1;
    n = 0;
    while (!(op_valid && op_ready) && n < TMO) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= TMO) begin
      errors++; $display("FAIL chain_handshake: timeout waiting op_valid, got 0 required 1");
    end else begin
      exp = exp_q.pop_front();
      got = '{a: A, b: B, as: Asign, bs: Bsign, m: Mode};
      if (got !== exp) begin
        errors++; $display("FAIL chain_operands: got=%h required=%h", got, exp);
      end
    end
    @(posedge clk); #1;
    op_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_signs_handshake();
    test_overflow();
    test_clear_in_req();
    test_done_keys();
`ifdef BCD_ENTRY_CHAIN_EN
    test_chain();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
